// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for the shared single-ported memory: fixed priority with
// fetch anti-starvation, latched request copy, variable-latency handshake and timeout abort.
module mem_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          done,
  output logic [2:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  state_t              state_q;
  logic [2:0]          gnt_q, done_q, err_q;
  logic [DATA_W-1:0]   rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q, mem_cs_q;
  logic [3:0]          starv_q, starv_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [1:0]          win_d;

  logic [ADDR_W-1:0]   port_addr  [3];
  logic [DATA_W-1:0]   port_wdata [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    assign port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // Fetch overrides the fixed order once it has lost MAX_WAIT arbitrations in a row.
  always_comb begin
    win_d   = 2'd0;
    starv_d = starv_q;
    if (req[0] && (starv_q >= MAX_WAIT_C)) win_d = 2'd0;
    else if (req[2])                       win_d = 2'd2;
    else if (req[1])                       win_d = 2'd1;
    else                                   win_d = 2'd0;
    if (req[0]) begin
      if (win_d == 2'd0)            starv_d = 4'd0;
      else if (starv_q < MAX_WAIT_C) starv_d = starv_q + 4'd1;
    end
  end

  assign tmo_d = tmo_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starv_q     <= '0;
      tmo_q       <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (|req) begin
            state_q     <= BUSY;
            gnt_q       <= 3'b001 << win_d;
            mem_cs_q    <= 1'b1;
            mem_we_q    <= we[win_d];
            mem_addr_q  <= port_addr[win_d];
            mem_wdata_q <= port_wdata[win_d];
            starv_q     <= starv_d;
          end
        end
        BUSY: begin
          tmo_q <= tmo_d;
          // A ready strobe on the timeout cycle still counts as a normal completion.
          if (mem_ready || (tmo_d == TIMEOUT_C)) begin
            if (mem_ready) begin
              done_q <= gnt_q;
              if (!mem_we_q) rdata_q <= mem_rdata;
            end else begin
              err_q <= gnt_q;
            end
            state_q     <= IDLE;
            gnt_q       <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the memory side is driven by hand from the
// stimulus sequence; outputs are checked 1 time unit after each rising edge.
module tb_mem_port_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req, we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt, done, err;
  logic [DATA_W-1:0]   rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_cs, mem_we, mem_ready;

  int pass_cnt = 0;
  int total    = 0;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_done_err", {done, err}, 6'b0);
    chk("reset_mem", {mem_cs, mem_we, mem_addr, mem_wdata}, 26'b0);
    chk("reset_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    step();
    $display("reset released");

    // Single fetch read; addr0 changes mid-transaction and must be ignored.
    req = 3'b001; we = 3'b000; addr[7:0] = 8'h10;
    step();
    chk("t1_gnt", gnt, 3'b001);
    chk("t1_cs_we", {mem_cs, mem_we}, 2'b10);
    chk("t1_addr", mem_addr, 8'h10);
    addr[7:0] = 8'h55;
    step();
    chk("t1_gnt2", gnt, 3'b001);
    chk("t1_addr_held", mem_addr, 8'h10);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    chk("t1_done", done, 3'b001);
    chk("t1_gnt_off", {gnt, mem_cs}, 4'b0);
    chk("t1_rdata", rdata, 16'hBEEF);
    req = 3'b000; mem_ready = 1'b0; mem_rdata = '0;
    step();
    chk("t1_done_pulse", done, 3'b000);
    chk("t1_rdata_hold", rdata, 16'hBEEF);
    $display("txn fetch read addr=10 rdata=%h", rdata);

    // All three request; expect writeback, operand, fetch in that order.
    req = 3'b111; we = 3'b100;
    addr = {8'h20, 8'h30, 8'h40}; wdata = {16'h1234, 16'h0000, 16'h0000};
    step();
    chk("t2_gnt_wb", gnt, 3'b100);
    chk("t2_wb_mem", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h20, 16'h1234});
    mem_ready = 1'b1;
    step();
    chk("t2_done_wb", done, 3'b100);
    chk("t2_idle_gap", mem_cs, 1'b0);
    chk("t2_rdata_write", rdata, 16'hBEEF);
    req = 3'b011; mem_ready = 1'b0;
    step();
    chk("t2_gnt_op", gnt, 3'b010);
    chk("t2_op_addr", {mem_we, mem_addr}, {1'b0, 8'h30});
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    step();
    chk("t2_done_op", done, 3'b010);
    chk("t2_rdata_op", rdata, 16'h5A5A);
    req = 3'b001; mem_ready = 1'b0;
    step();
    chk("t2_gnt_fetch", gnt, 3'b001);
    chk("t2_fetch_addr", mem_addr, 8'h40);
    mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    step();
    chk("t2_done_fetch", done, 3'b001);
    chk("t2_rdata_fetch", rdata, 16'h0F0F);
    req = 3'b000; mem_ready = 1'b0;
    step();
    $display("txn priority order wb->op->fetch complete");

    // Starvation: writeback keeps re-requesting; fetch wins the 5th arbitration.
    req = 3'b101; we = 3'b100; addr = {8'h20, 8'h00, 8'h11}; mem_rdata = 16'h1111;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t3_gnt_arb%0d", k), gnt, (k == 5) ? 3'b001 : 3'b100);
      mem_ready = 1'b1;
      step();
      chk($sformatf("t3_done_arb%0d", k), done, (k == 5) ? 3'b001 : 3'b100);
      mem_ready = 1'b0;
      if (k == 5) req = 3'b000;
      step();
      $display("txn starvation arbitration %0d done=%b", k, done);
    end
    chk("t3_rdata", rdata, 16'h1111);
    req = 3'b101;
    step();
    chk("t3_counter_cleared", gnt, 3'b100);
    mem_ready = 1'b1;
    step();
    chk("t3_done_after", done, 3'b100);
    req = 3'b000; mem_ready = 1'b0;
    step();

    // Operand read with no ready: abort after 15 BUSY cycles.
    req = 3'b010; we = 3'b000; addr = {8'h00, 8'h33, 8'h00}; mem_rdata = 16'hDEAD;
    step();
    for (int c = 0; c < 14; c++) step();
    chk("t4_gnt_last_busy", gnt, 3'b010);
    chk("t4_no_err_yet", err, 3'b000);
    step();
    chk("t4_err", err, 3'b010);
    chk("t4_no_done", done, 3'b000);
    chk("t4_gnt_off", {gnt, mem_cs}, 4'b0);
    chk("t4_rdata_kept", rdata, 16'h1111);
    req = 3'b001; addr = {8'h00, 8'h00, 8'h12};
    step();
    chk("t4_err_pulse", err, 3'b000);
    chk("t4_accept_fetch", gnt, 3'b001);
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    step();
    chk("t4_fetch_done", done, 3'b001);
    chk("t4_fetch_rdata", rdata, 16'h2222);
    req = 3'b000; mem_ready = 1'b0;
    step();
    $display("txn operand timeout err then fetch rdata=%h", rdata);

    // Ready arriving exactly on the timeout cycle completes normally.
    req = 3'b010; addr = {8'h00, 8'h44, 8'h00};
    step();
    for (int c = 0; c < 14; c++) step();
    mem_ready = 1'b1; mem_rdata = 16'h3333;
    step();
    chk("t5_done", done, 3'b010);
    chk("t5_no_err", err, 3'b000);
    chk("t5_rdata", rdata, 16'h3333);
    req = 3'b000; mem_ready = 1'b0;
    step();
    $display("txn ready on timeout cycle done=%b", done);

    // Asynchronous reset mid-BUSY discards the transaction.
    req = 3'b001; addr = {8'h00, 8'h00, 8'h66};
    step();
    chk("t6_gnt_before", gnt, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {gnt, mem_cs, done, err}, 10'b0);
    chk("t6_async_mem", {mem_addr, rdata}, 24'h0);
    req = 3'b000;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle_after", {gnt, done, err}, 9'b0);
    req = 3'b001;
    step();
    chk("t6_regrant", gnt, 3'b001);
    mem_ready = 1'b1; mem_rdata = 16'h4444;
    step();
    chk("t6_done", done, 3'b001);
    chk("t6_rdata", rdata, 16'h4444);
    req = 3'b000; mem_ready = 1'b0;
    step();
    $display("txn reset mid-busy then fetch rdata=%h", rdata);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
